// File: rtl/rx_frame_guard_if.sv
// rx_frame_guard_if
// Groups the frame input from the SPI slave and the qualified command/status
// outputs of rx_frame_guard.
//   rx_data    frame from spi_slave, valid only with rx_valid
//   rx_valid   one-cycle pulse: frame complete
//   cmd_data   last good write payload, joint-enable field masked unless linked
//   cmd_strobe one-cycle pulse: cmd_data just updated
//   link_ok    host link healthy
//   timed_out  comms watchdog expired
//   frame_cnt  good frame count (wrapping)
//   err_cnt    bad header count (saturating)
// master: frame source side; slave: the guard itself.
interface rx_frame_guard_if #(
  parameter int BUFFER_SIZE = 240
);
  logic [BUFFER_SIZE-1:0] rx_data;
  logic                   rx_valid;
  logic [BUFFER_SIZE-1:0] cmd_data;
  logic                   cmd_strobe;
  logic                   link_ok;
  logic                   timed_out;
  logic [15:0]            frame_cnt;
  logic [7:0]             err_cnt;

  modport master (
    output rx_data, rx_valid,
    input  cmd_data, cmd_strobe, link_ok, timed_out, frame_cnt, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output cmd_data, cmd_strobe, link_ok, timed_out, frame_cnt, err_cnt
  );
endinterface

// File: rtl/rx_frame_guard.sv
// rx_frame_guard
// Qualifies each completed SPI frame by its 32-bit header, latches write
// payloads into a held command register, counts good/bad frames and runs a
// comms watchdog that masks the joint enables when the host goes quiet.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  rx_frame_guard_if.slave (frame in, command/status out)
module rx_frame_guard #(
  parameter int          BUFFER_SIZE    = 240,
  parameter logic [31:0] HEADER_WRITE   = 32'h74697277,
  parameter logic [31:0] HEADER_READ    = 32'h72656164,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2400000,
  parameter int          EN_LSB         = 8
) (
  input  logic             clk,
  input  logic             rst,
  rx_frame_guard_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [BUFFER_SIZE-1:0] payload_reg, payload_next;
  logic                   strobe_reg, strobe_next;
  logic [15:0]            frame_cnt_reg, frame_cnt_next;
  logic [7:0]             err_cnt_reg, err_cnt_next;
  logic [23:0]            wd_cnt_reg, wd_cnt_next;

  logic [31:0]            hdr;
  logic                   good_w, good_r, good_frame, bad_frame;
  logic [BUFFER_SIZE-1:0] cmd_masked;

  // The host sends the header least significant byte first, so the top byte
  // of the frame lands in hdr[7:0].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hdr
      assign hdr[8*gi +: 8] = bus.rx_data[BUFFER_SIZE-1-8*gi -: 8];
    end
  endgenerate

  assign good_w     = (hdr == HEADER_WRITE);
  assign good_r     = (hdr == HEADER_READ);
  assign good_frame = bus.rx_valid & (good_w | good_r);
  assign bad_frame  = bus.rx_valid & ~(good_w | good_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_WAIT;
      payload_reg   <= '0;
      strobe_reg    <= 1'b0;
      frame_cnt_reg <= 16'd0;
      err_cnt_reg   <= 8'd0;
      wd_cnt_reg    <= 24'd0;
    end else begin
      state_reg     <= state_next;
      payload_reg   <= payload_next;
      strobe_reg    <= strobe_next;
      frame_cnt_reg <= frame_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      wd_cnt_reg    <= wd_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    payload_next   = payload_reg;
    strobe_next    = 1'b0;
    frame_cnt_next = frame_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    wd_cnt_next    = wd_cnt_reg;

    if (good_frame) begin
      frame_cnt_next = frame_cnt_reg + 16'd1;
    end
    if (good_frame && good_w) begin
      payload_next = bus.rx_data;
      strobe_next  = 1'b1;
    end
    if (bad_frame && (err_cnt_reg != 8'hFF)) begin
      err_cnt_next = err_cnt_reg + 8'd1;
    end

    case (state_reg)
      ST_WAIT: begin
        wd_cnt_next = 24'd0;
        if (good_frame) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A good frame arriving on the expiry cycle keeps the link up.
        if (good_frame) begin
          wd_cnt_next = 24'd0;
        end else if (wd_cnt_reg == TIMEOUT_CYCLES - 24'd1) begin
          state_next  = ST_TIMEOUT;
          wd_cnt_next = 24'd0;
        end else begin
          wd_cnt_next = wd_cnt_reg + 24'd1;
        end
      end
      ST_TIMEOUT: begin
        wd_cnt_next = 24'd0;
        if (good_frame) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next  = ST_WAIT;
        wd_cnt_next = 24'd0;
      end
    endcase
  end

  // The payload is held across a timeout; only the enable field is gated so
  // the old enables come back if the link recovers via a read frame.
  always_comb begin
    cmd_masked = payload_reg;
    if (state_reg != ST_RUN) begin
      cmd_masked[EN_LSB +: 8] = 8'h00;
    end
  end

  assign bus.cmd_data   = cmd_masked;
  assign bus.cmd_strobe = strobe_reg;
  assign bus.link_ok    = (state_reg == ST_RUN);
  assign bus.timed_out  = (state_reg == ST_TIMEOUT);
  assign bus.frame_cnt  = frame_cnt_reg;
  assign bus.err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_rx_frame_guard.sv
// tb_rx_frame_guard
// Drives directed and randomized frames into rx_frame_guard (watchdog shortened
// to 100 cycles) and compares every cycle against a behavioural model of the
// link: "linked since the last good frame, timed out after 100 silent cycles".
module tb_rx_frame_guard;
  localparam int          B    = 240;
  localparam int          T    = 100;
  localparam logic [31:0] HW   = 32'h74697277;
  localparam logic [31:0] HR   = 32'h72656164;
  localparam logic [31:0] HBAD = 32'hDEADBEEF;

  logic clk;
  logic rst;

  rx_frame_guard_if #(.BUFFER_SIZE(B)) bus ();

  rx_frame_guard #(
    .BUFFER_SIZE   (B),
    .HEADER_WRITE  (HW),
    .HEADER_READ   (HR),
    .TIMEOUT_CYCLES(24'd100),
    .EN_LSB        (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // ---------------- behavioural model ----------------
  logic [B-1:0] m_payload = '0;
  logic         m_strobe  = 1'b0;
  logic         m_linked  = 1'b0;   // at least one good frame since reset
  logic         m_timed   = 1'b0;   // silence exceeded the limit since then
  int           m_silent  = 0;
  logic [15:0]  m_frames  = 16'd0;
  logic [7:0]   m_errs    = 8'd0;

  function automatic logic [31:0] hdr_of(input logic [B-1:0] f);
    return {f[B-25:B-32], f[B-17:B-24], f[B-9:B-16], f[B-1:B-8]};
  endfunction

  function automatic logic [B-1:0] mk_frame(input logic [31:0] h, input logic [B-33:0] body);
    return {h[7:0], h[15:8], h[23:16], h[31:24], body};
  endfunction

  function automatic logic [B-33:0] rand_body();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w[B-33:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_payload <= '0;
      m_strobe  <= 1'b0;
      m_linked  <= 1'b0;
      m_timed   <= 1'b0;
      m_silent  <= 0;
      m_frames  <= 16'd0;
      m_errs    <= 8'd0;
    end else if (bus.rx_valid && (hdr_of(bus.rx_data) == HW || hdr_of(bus.rx_data) == HR)) begin
      m_frames <= m_frames + 16'd1;
      m_linked <= 1'b1;
      m_timed  <= 1'b0;
      m_silent <= 0;
      m_strobe <= (hdr_of(bus.rx_data) == HW);
      if (hdr_of(bus.rx_data) == HW) m_payload <= bus.rx_data;
    end else begin
      m_strobe <= 1'b0;
      if (bus.rx_valid && m_errs != 8'hFF) m_errs <= m_errs + 8'd1;
      if (m_linked && !m_timed) begin
        if (m_silent + 1 == T) begin
          m_timed  <= 1'b1;
          m_silent <= 0;
        end else begin
          m_silent <= m_silent + 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [B-1:0] f);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = f;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [B-1:0]  f_w1, f_bad, f_rd;
  logic [B-33:0] body;
  int            cnt;

  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;

    fork
      forever begin
        logic [B-1:0] exp_cmd;
        @(negedge clk);
        if (chk_en) begin
          exp_cmd = m_payload;
          if (!(m_linked && !m_timed)) exp_cmd[15:8] = 8'h00;
          check("cmd_data", bus.cmd_data, exp_cmd);
          check("cmd_strobe", B'(bus.cmd_strobe), B'(m_strobe));
          check("link_ok", B'(bus.link_ok), B'(m_linked && !m_timed));
          check("timed_out", B'(bus.timed_out), B'(m_linked && m_timed));
          check("frame_cnt", B'(bus.frame_cnt), B'(m_frames));
          check("err_cnt", B'(bus.err_cnt), B'(m_errs));
        end
      end
    join_none

    // Reset state
    do_reset();
    chk_en = 1'b1;
    check("rst_cmd", bus.cmd_data, '0);
    check("rst_link", B'(bus.link_ok), B'(0));
    check("rst_frames", B'(bus.frame_cnt), B'(0));

    // 1: write frame, enables F8, DOUT 15
    body = rand_body();
    body[15:0] = 16'hF815;
    f_w1 = mk_frame(HW, body);
    send(f_w1);
    check("t1_strobe", B'(bus.cmd_strobe), B'(1));
    check("t1_link", B'(bus.link_ok), B'(1));
    check("t1_en", B'(bus.cmd_data[15:8]), B'(8'hF8));
    check("t1_dout", B'(bus.cmd_data[5:0]), B'(6'h15));
    check("t1_frames", B'(bus.frame_cnt), B'(1));

    // 2: bad header leaves payload alone
    f_bad = mk_frame(HBAD, rand_body());
    send(f_bad);
    check("t2_cmd", bus.cmd_data, f_w1);
    check("t2_strobe", B'(bus.cmd_strobe), B'(0));
    check("t2_err", B'(bus.err_cnt), B'(1));

    // 3: timeout exactly T cycles after link_ok rises
    do_reset();
    send(f_w1);
    check("t3_link", B'(bus.link_ok), B'(1));
    cnt = 0;
    while (!bus.timed_out && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("t3_delay", B'(cnt), B'(100));
    check("t3_en_masked", B'(bus.cmd_data[15:8]), B'(0));
    check("t3_held", bus.cmd_data[B-1:16], f_w1[B-1:16]);

    // 4: read frame recovers, old enables restored
    f_rd = mk_frame(HR, rand_body());
    send(f_rd);
    check("t4_link", B'(bus.link_ok), B'(1));
    check("t4_en", B'(bus.cmd_data[15:8]), B'(8'hF8));
    check("t4_strobe", B'(bus.cmd_strobe), B'(0));
    check("t4_frames", B'(bus.frame_cnt), B'(2));

    // 5: good frame on the expiry cycle wins
    repeat (98) @(negedge clk);
    send(f_rd);
    check("t5_no_to", B'(bus.timed_out), B'(0));
    repeat (99) @(negedge clk);
    check("t5_before", B'(bus.timed_out), B'(0));
    @(negedge clk);
    check("t5_after", B'(bus.timed_out), B'(1));

    // err_cnt saturation with back-to-back bad frames
    bus.rx_valid = 1'b1;
    bus.rx_data  = f_bad;
    repeat (300) @(negedge clk);
    bus.rx_valid = 1'b0;
    check("t2_err_sat", B'(bus.err_cnt), B'(8'hFF));

    // reset in TIMEOUT beats a simultaneous good frame
    rst          = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = f_w1;
    @(negedge clk);
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    check("rst_pri_cmd", bus.cmd_data, '0);
    check("rst_pri_frames", B'(bus.frame_cnt), B'(0));
    check("rst_pri_err", B'(bus.err_cnt), B'(0));
    check("rst_pri_link", B'(bus.link_ok), B'(0));

    // Randomized segments with varying traffic density
    for (int seg = 0; seg < 16; seg++) begin
      int dens;
      int len;
      dens = $urandom_range(0, 3);
      len  = $urandom_range(100, 200);
      for (int c = 0; c < len; c++) begin
        int k;
        logic [31:0] h;
        @(negedge clk);
        rst = ($urandom_range(0, 299) == 0);
        case (dens)
          0:       bus.rx_valid = ($urandom_range(0, 99) < 1);
          1:       bus.rx_valid = ($urandom_range(0, 99) < 5);
          2:       bus.rx_valid = ($urandom_range(0, 99) < 30);
          default: bus.rx_valid = ($urandom_range(0, 99) < 80);
        endcase
        k = $urandom_range(0, 9);
        if (k < 4)      h = HW;
        else if (k < 7) h = HR;
        else if (k < 8) h = HBAD;
        else            h = HW ^ (32'h1 << $urandom_range(0, 31));
        bus.rx_data = mk_frame(h, rand_body());
      end
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.rx_valid = 1'b0;

    // 6: frame counter reaches FFFF, times out, then wraps
    do_reset();
    bus.rx_valid = 1'b1;
    bus.rx_data  = f_rd;
    repeat (65535) @(negedge clk);
    bus.rx_valid = 1'b0;
    check("t6_ffff", B'(bus.frame_cnt), B'(16'hFFFF));
    repeat (100) @(negedge clk);
    check("t6_to", B'(bus.timed_out), B'(1));
    send(f_rd);
    check("t6_wrap", B'(bus.frame_cnt), B'(0));
    check("t6_relink", B'(bus.link_ok), B'(1));

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
